jk_excitation_driver: RTL



---
 rtl/jk_drv_pkg.sv | 25 ++
 rtl/jk_excitation_driver_if.sv | 13 +
 rtl/jk_tgt_fifo.sv | 54 +++++
 rtl/jk_excitation_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types and helpers for the JK excitation driver.
//   drv_state_t : FSM state encoding (IDLE, DRIVE, SETTLE)
//   excite()    : JK excitation table, returns {J,K} for a q -> t transition
//                 with don't-care positions filled by dc.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } drv_state_t;

  function automatic logic [1:0] excite(input logic q, input logic t, input logic dc);
    logic [1:0] jk;
    case ({q, t})
      2'b00:   jk = {1'b0, dc};
      2'b01:   jk = {1'b1, dc};
      2'b10:   jk = {dc, 1'b1};
      2'b11:   jk = {dc, 1'b0};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// jk_excitation_driver_if: valid/ready target stream into the JK driver.
//   tgt_valid : producer offers a target bit
//   tgt_q     : desired next state of the driven JK element
//   tgt_ready : driver can accept (FIFO not full)
// Modports: master = producer, slave = driver.
interface jk_excitation_driver_if;
  logic tgt_valid;
  logic tgt_q;
  logic tgt_ready;

  modport master (output tgt_valid, output tgt_q, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_q, output tgt_ready);
endinterface

// File: rtl/jk_tgt_fifo.sv
// jk_tgt_fifo: 1-bit wide target FIFO, DEPTH entries (power of two).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request (ignored when empty), head data
//   full, empty  : status flags
//   count        : occupancy, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jk_tgt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns a stream of desired next-state bits into J/K
// drive plus a one-cycle En pulse for a downstream JK latch or flip-flop.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tgt        : target stream (slave modport of jk_excitation_driver_if)
//   J, K, En   : registered drive to the JK element
//   q_model    : tracked state of the driven element
//   busy       : FSM active or targets still queued
//   drive_cnt  : completed drive pulses, wraps at 256
// Optional (macro JK_DRV_CHECK_EN):
//   q_fb       : Q of the driven element
//   mismatch   : sticky flag, q_fb disagreed with q_model at a check point
//   err_cnt    : saturating count of such disagreements
//
// state  | meaning
// IDLE   | waiting for a target; pops and registers J/K/En when one is queued
// DRIVE  | En high for this cycle; q_model takes the target on exit
// SETTLE | En/J/K low for SETTLE_CYCLES cycles before the next target
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int DC_POLICY     = 0,
  parameter bit INIT_Q        = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  jk_excitation_driver_if.slave        tgt,
  output logic                         J,
  output logic                         K,
  output logic                         En,
  output logic                         q_model,
  output logic                         busy,
  output logic [7:0]                   drive_cnt
`ifdef JK_DRV_CHECK_EN
  ,
  input  logic                         q_fb,
  output logic                         mismatch,
  output logic [7:0]                   err_cnt
`endif
);

  localparam int         AW          = $clog2(DEPTH);
  localparam logic       DC          = (DC_POLICY != 0);
  localparam int         SETTLE_M1   = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_M1);

  drv_state_t  state, state_nxt;
  logic [3:0]  settle_cnt, settle_nxt;
  logic        tgt_reg;
  logic        j_nxt, k_nxt, en_nxt;
  logic        pop;
  logic        fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tgt.tgt_valid),
    .din   (tgt.tgt_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tgt.tgt_ready = !fifo_full;
  assign busy          = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    pop        = 1'b0;
    j_nxt      = 1'b0;
    k_nxt      = 1'b0;
    en_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          {j_nxt, k_nxt} = excite(q_model, fifo_dout, DC);
          en_nxt         = 1'b1;
          state_nxt      = DRIVE;
        end
      end
      DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = IDLE;
        else                    settle_nxt = settle_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      tgt_reg    <= INIT_Q;
      J          <= 1'b0;
      K          <= 1'b0;
      En         <= 1'b0;
      q_model    <= INIT_Q;
      drive_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      J          <= j_nxt;
      K          <= k_nxt;
      En         <= en_nxt;
      if (pop) tgt_reg <= fifo_dout;
      // The element samples J/K during DRIVE, so the model follows on exit.
      if (state == DRIVE) begin
        q_model   <= tgt_reg;
        drive_cnt <= drive_cnt + 8'd1;
      end
    end
  end

`ifdef JK_DRV_CHECK_EN
  logic after_drive;
  logic chk_now;

  // With no settle window, the check falls on the cycle right after DRIVE.
  assign chk_now = (SETTLE_CYCLES == 0) ? after_drive
                                        : ((state == SETTLE) && (settle_cnt == 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      after_drive <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      after_drive <= (state == DRIVE);
      if (chk_now && (q_fb != q_model)) begin
        mismatch <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
